// File: rtl/latch_pkg.sv
// latch_pkg: definitions shared by the latch feeder RTL and the latch bench.
//   LATCH_WIDTH   : default data word width of the downstream latch.
//   latch_state_e : feeder sequencing states (IDLE/SETUP/STROBE/HOLD).
package latch_pkg;

    localparam int LATCH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } latch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer feeding the latch sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and level cleared)
//   push       : write push_data this edge (ignored while full)
//   pop        : drop the head word this edge (ignored while empty)
//   push_data  : word to write
//   pop_data   : current head word (valid while !empty)
//   full/empty : level == DEPTH / level == 0
//   level      : words currently stored
module sync_fifo
    import latch_pkg::*;
#(
    parameter int WIDTH = LATCH_WIDTH,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
        else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/latch_feeder.sv
// latch_feeder: buffers upstream words and presents each one to a transparent
// latch with a setup cycle, a one-cycle write strobe and a HOLD-cycle hold.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_data     : upstream word
//   in_valid    : in_data valid this cycle
//   in_ready    : a word is accepted this cycle (buffer not full)
//   latch_we    : registered latch write strobe
//   latch_data  : registered latch data, stable from SETUP through HOLD
//   busy        : sequencer outside IDLE
//   level       : words currently buffered
//
// state     | meaning
// ST_IDLE   | waiting for a buffered word; pops it into latch_data
// ST_SETUP  | latch_data settling before the strobe
// ST_STROBE | latch_we high for this single cycle
// ST_HOLD   | latch_data held for HOLD cycles after the strobe
module latch_feeder
    import latch_pkg::*;
#(
    parameter int WIDTH = LATCH_WIDTH,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             latch_we,
    output logic [WIDTH-1:0] latch_data,
    output logic             busy,
    output logic [LVL_W-1:0] level
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    latch_state_e     state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             latch_we_q, latch_we_d;
    logic [WIDTH-1:0] latch_data_q, latch_data_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .pop       (fifo_pop),
        .push_data (in_data),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign in_ready   = !fifo_full;
    assign busy       = (state_q != ST_IDLE);
    assign latch_we   = latch_we_q;
    assign latch_data = latch_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            latch_we_q   <= 1'b0;
            latch_data_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            latch_we_q   <= latch_we_d;
            latch_data_q <= latch_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   if (hold_cnt_q == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are next-values of registers: latch_we_d is raised in SETUP so
    // the registered strobe is high exactly while the FSM sits in STROBE.
    always_comb begin
        fifo_pop     = 1'b0;
        latch_we_d   = 1'b0;
        latch_data_d = latch_data_q;
        hold_cnt_d   = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    latch_data_d = fifo_head;
                end
            end
            ST_SETUP:  latch_we_d = 1'b1;
            ST_STROBE: hold_cnt_d = CNT_LOAD;
            ST_HOLD: begin
                if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - CNT_ONE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_latch_feeder.sv
// tb_latch_feeder: self-checking bench for latch_feeder (WIDTH 8, DEPTH 4, HOLD 2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_latch_feeder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       latch_we;
    logic [7:0] latch_data;
    logic       busy;
    logic [2:0] level;

    latch_feeder #(
        .WIDTH (8),
        .DEPTH (4),
        .HOLD  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .latch_we   (latch_we),
        .latch_data (latch_data),
        .busy       (busy),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_strobes = 0;
    logic [7:0] exp_q[$];
    int         strobe_t[$];
    logic       rst_glitch = 1'b1;
    logic [7:0] prev_data = '0;
    logic       prev_busy = 1'b0;
    logic       prev_we   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // Scoreboard consumer, strobe width and data-stability monitor.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        cyc++;
        if (rst_n && latch_we) begin
            n_strobes++;
            strobe_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: strobe with data %0d, expected no strobe", latch_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_data", int'(latch_data), int'(exp_w));
            end
        end
        if (!rst_n || rst_glitch) begin
            prev_busy = 1'b0;
            prev_we   = 1'b0;
            if (rst_n) rst_glitch = 1'b0;
        end else begin
            // latch_data may only move on the IDLE->SETUP edge, i.e. after a non-busy sample.
            if (prev_busy) check("stable_data", int'(latch_data), int'(prev_data));
            if (prev_we)   check("we_width", int'(latch_we), 0);
            prev_busy = busy;
            prev_we   = latch_we;
        end
        prev_data = latch_data;
    end

    // Offer one word until accepted; returns the number of extra cycles waited.
    task automatic push_word(input logic [7:0] d, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) timeout("push_wait");
        else exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || level != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || level != 0) timeout(name);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       e_we;
        logic       e_busy;
        logic [2:0] e_lvl;
        logic       e_rdy;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;

        // Single word A5 pushed at edge k (row 0 precedes edge k, row n follows edge k+n-1).
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'hA5};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'hA5};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",    int'(latch_we),   0);
        check("rst_data",  int'(latch_data), 0);
        check("rst_busy",  int'(busy),       0);
        check("rst_level", int'(level),      0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].dat;
            @(negedge clk);
            check($sformatf("vec%0d_we", i),    int'(latch_we),   int'(vecs[i].e_we));
            check($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].e_busy));
            check($sformatf("vec%0d_level", i), int'(level),      int'(vecs[i].e_lvl));
            check($sformatf("vec%0d_ready", i), int'(in_ready),   int'(vecs[i].e_rdy));
            check($sformatf("vec%0d_data", i),  int'(latch_data), int'(vecs[i].e_data));
            if (vecs[i].vld && in_ready) exp_q.push_back(vecs[i].dat);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Burst 00..05: the first word is popped one edge after its push, so the
        // buffer fills on the fifth push; the next pop is one word period later.
        strobe_t.delete();
        for (int i = 0; i < 5; i++) push_word(8'(i), w);
        @(negedge clk);
        check("burst_ready_full", int'(in_ready), 0);
        check("burst_level_full", int'(level), 4);
        push_word(8'h05, w);
        check("burst_ready_return", w, 1);
        wait_idle("burst_drain");
        check("burst_strobes", strobe_t.size(), 6);
        for (int i = 1; i < strobe_t.size(); i++)
            check($sformatf("burst_period%0d", i), strobe_t[i] - strobe_t[i-1], 5);

        // Simultaneous push and pop with two words buffered.
        push_word(8'hA0, w);
        push_word(8'hA1, w);
        push_word(8'hA2, w);
        begin
            int n = 0;
            @(negedge clk);
            while (busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (busy) timeout("simul_idle");
        end
        check("simul_level_before", int'(level), 2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        exp_q.push_back(8'hA3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("simul_level_after", int'(level), 2);
        check("simul_busy", int'(busy), 1);
        wait_idle("simul_drain");

        // Reset while strobing: strobe drops at once, buffered words discarded.
        push_word(8'h11, w);
        push_word(8'h22, w);
        push_word(8'h33, w);
        begin
            int n = 0;
            @(negedge clk);
            while (!latch_we && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!latch_we) timeout("rst_strobe_wait");
        end
        #2;
        rst_glitch = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("midrst_we",    int'(latch_we),   0);
        check("midrst_level", int'(level),      0);
        check("midrst_busy",  int'(busy),       0);
        check("midrst_data",  int'(latch_data), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_we_held", int'(latch_we), 0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Wrap: 256 words with random gaps, every one delivered once, in order.
        base = n_strobes;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            push_word(8'(i), w);
        end
        wait_idle("wrap_drain");
        check("wrap_strobes", n_strobes - base, 256);
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
